cpu_exec_shell: RTL

Parametrised execution shell between the `riscv_cpu` core and external simulation memory. It replaces direct single-cycle instruction/data wiring with valid/ready handshakes, and steps the core one instruction at a time through a fetch/execute/memory state machine. It also detects `ebreak` to halt, counts cycles and retired instructions, and exposes a selectable multi-channel probe port. The generalised debug-probe outputs replace the fixed 16/32-bit test outputs.

---
 rtl/cpu_exec_shell_if.sv | 33 +++
 rtl/cpu_exec_shell.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_shell_if.sv
// Memory-side handshake bundle for cpu_exec_shell: instruction fetch port
// and data access port, both valid/ready. The shell is the master; the
// external simulation memory is the slave.
interface cpu_exec_shell_if #(
    parameter int XLEN = 32
);
    logic            imem_valid;
    logic            imem_ready;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    logic            dmem_valid;
    logic            dmem_ready;
    logic            dmem_wen;
    logic [2:0]      dmem_memop;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output imem_valid, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_valid, dmem_wen, dmem_memop, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_valid, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_valid, dmem_wen, dmem_memop, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/cpu_exec_shell.sv
// Execution shell around the riscv_cpu core. Steps the core one instruction
// at a time through FETCH -> EXEC -> (MEM) using valid/ready handshakes to
// memory, halts on ebreak or on a handshake watchdog expiry, keeps cycle and
// retired-instruction counters, and provides a registered probe mux.
// Optional feature macro: CPU_EXEC_SHELL_TRACE_EN adds a retirement trace port.
module cpu_exec_shell #(
    parameter int              XLEN     = 32,
    parameter int              PROBE_CH = 4,
    parameter int              TIMEOUT  = 1024,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              SEL_W    = (PROBE_CH > 1) ? $clog2(PROBE_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          core_pc,
    output logic [31:0]              core_inst,
    output logic                     core_step,
    input  logic                     core_mem_req,
    input  logic                     core_mem_wen,
    input  logic [2:0]               core_memop,
    input  logic [XLEN-1:0]          core_mem_addr,
    input  logic [XLEN-1:0]          core_mem_wdata,
    output logic [XLEN-1:0]          core_mem_rdata,
    input  logic [XLEN-1:0]          core_a0,
    cpu_exec_shell_if.master         mem,
    input  logic [PROBE_CH*XLEN-1:0] probe_bus,
    input  logic [SEL_W-1:0]         probe_sel,
    output logic [XLEN-1:0]          probe_out,
    output logic [XLEN-1:0]          pc,
    output logic                     halted,
    output logic                     fault,
    output logic [XLEN-1:0]          halt_code,
    output logic [63:0]              cycle_cnt,
    output logic [63:0]              instret_cnt
`ifdef CPU_EXEC_SHELL_TRACE_EN
    ,
    output logic                     trace_valid,
    output logic [XLEN-1:0]          trace_pc,
    output logic [31:0]              trace_inst
`endif
);
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam int          WD_W        = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_rdata;
    logic [WD_W-1:0] r_wdog;
    logic            r_halted;
    logic            r_fault;
    logic [XLEN-1:0] r_halt_code;
    logic [63:0]     r_cycle;
    logic [63:0]     r_instret;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_probe;

    logic            w_imem_valid;
    logic            w_dmem_valid;
    logic            w_step;
    logic            w_imem_hs;
    logic            w_dmem_hs;
    logic            w_waiting;
    logic            w_wd_expire;
    logic            w_is_ebreak;
    logic [XLEN-1:0] w_probe;

    assign w_imem_hs   = w_imem_valid && mem.imem_ready;
    assign w_dmem_hs   = w_dmem_valid && mem.dmem_ready;
    assign w_waiting   = (w_imem_valid && !mem.imem_ready) ||
                         (w_dmem_valid && !mem.dmem_ready);
    assign w_wd_expire = w_waiting && (r_wdog == WD_LAST);
    assign w_is_ebreak = (r_state == S_EXEC) && (r_inst == INST_EBREAK);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Next-state decode and handshake/step strobes
    always_comb begin
        w_next       = r_state;
        w_imem_valid = 1'b0;
        w_dmem_valid = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_valid = 1'b1;
                if (mem.imem_ready)   w_next = S_EXEC;
                else if (w_wd_expire) w_next = S_HALT;
            end
            S_EXEC: begin
                if (r_inst == INST_EBREAK) begin
                    w_next = S_HALT;
                end else if (core_mem_req) begin
                    w_next = S_MEM;
                end else begin
                    w_step = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                w_dmem_valid = 1'b1;
                if (mem.dmem_ready) begin
                    w_step = 1'b1;
                    w_next = S_FETCH;
                end else if (w_wd_expire) begin
                    w_next = S_HALT;
                end
            end
            default: w_next = S_HALT;
        endcase
    end

    // Instruction latch: holds the fetched word stable for the core through EXEC/MEM
    always_ff @(posedge clk) begin
        if (rst)            r_inst <= INST_NOP;
        else if (w_imem_hs) r_inst <= mem.imem_rdata;
    end

    // Load data latch; stores leave the previous value in place
    always_ff @(posedge clk) begin
        if (rst)                            r_rdata <= '0;
        else if (w_dmem_hs && !core_mem_wen) r_rdata <= mem.dmem_rdata;
    end

    // Handshake watchdog: counts consecutive waiting cycles, cleared otherwise
    always_ff @(posedge clk) begin
        if (rst)            r_wdog <= '0;
        else if (w_waiting) r_wdog <= r_wdog + 1'b1;
        else                r_wdog <= '0;
    end

    // Halt status, captured on the single edge that enters HALT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
            r_halt_code <= '0;
        end else if (r_state != S_HALT && w_next == S_HALT) begin
            r_halted <= 1'b1;
            if (w_is_ebreak) begin
                r_halt_code <= core_a0;
            end else begin
                r_fault     <= 1'b1;
                r_halt_code <= core_pc;
            end
        end
    end

    // Performance counters; cycle counter freezes once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle   <= r_cycle + 64'd1;
            if (w_step)            r_instret <= r_instret + 64'd1;
        end
    end

    // Probe channel select; out-of-range selects fall back to channel 0
    always_comb begin
        w_probe = probe_bus[XLEN-1:0];
        for (int k = 0; k < PROBE_CH; k++) begin
            if (32'(probe_sel) == k) w_probe = probe_bus[k*XLEN +: XLEN];
        end
    end

    // Registered PC copy and probe output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_probe <= '0;
        end else begin
            r_pc    <= core_pc;
            r_probe <= w_probe;
        end
    end

`ifdef CPU_EXEC_SHELL_TRACE_EN
    logic            r_trace_valid;
    logic [XLEN-1:0] r_trace_pc;
    logic [31:0]     r_trace_inst;

    // Retirement trace: one record in the cycle after each step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_inst  <= '0;
        end else begin
            r_trace_valid <= w_step;
            if (w_step) begin
                r_trace_pc   <= core_pc;
                r_trace_inst <= r_inst;
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_inst  = r_trace_inst;
`endif

    assign mem.imem_valid = w_imem_valid;
    assign mem.imem_addr  = core_pc;
    assign mem.dmem_valid = w_dmem_valid;
    assign mem.dmem_wen   = core_mem_wen;
    assign mem.dmem_memop = core_memop;
    assign mem.dmem_addr  = core_mem_addr;
    assign mem.dmem_wdata = core_mem_wdata;

    // Load data is bypassed during the handshake cycle since the core commits on that edge
    assign core_mem_rdata = (w_dmem_hs && !core_mem_wen) ? mem.dmem_rdata : r_rdata;
    assign core_inst      = r_inst;
    assign core_step      = w_step;
    assign probe_out      = r_probe;
    assign pc             = r_pc;
    assign halted         = r_halted;
    assign fault          = r_fault;
    assign halt_code      = r_halt_code;
    assign cycle_cnt      = r_cycle;
    assign instret_cnt    = r_instret;
endmodule
